qa_frame_release: RTL and testbench
===================================

// Module: qa_frame_release
// PURPOSE
// - Returns consumed read frames to the host in the QA polled driver.
// - Counts frame-release pulses from the frame reader.
// - For each pulse, issues one cache-line write to that frame's header line (chunk 0).
//   Software then sees the frame as free.
// - Sits beside frame_reader. It shares the write channel through the frame_arb_t request
//   and write_grant.
// PARAMETERS
// - MAX_PENDING      8  max releases queued while waiting for write grants
// - LOG_FRAME_BASE_POINTER / LOG_FRAME_NUMBER / LOG_FRAME_CHUNKS
//   - Defaults come from qa.vh.
//   - Address field widths; they must match frame_reader.
// PORTS
// - clk                 in   1       single clock domain, rising edge
// - resetb              in   1       asynchronous, active-high reset (1 = reset)
// - csr                 in   t_CSR_AFU_STATE   only csr.afu_en is used
// - frame_base_pointer  in   LOG_FRAME_BASE_POINTER   read-frame region base, already line aligned
// - release_frame       in   1       1-cycle pulse: the oldest in-flight frame has been fully consumed
// - write_grant         in   channel_grant_arb_t   writer_grant=1 means this cycle's write request was accepted
// - frame_reader        out  frame_arb_t   release-write request
//   - Drives .write.request and .write_header.
//   - .read.request, .read_header and .data are driven 0; the parent supplies the write data.
// BEHAVIOUR
// - State: frame_number (LOG_FRAME_NUMBER bits) and pending counter
//   (width $clog2(MAX_PENDING+1)).
// - Reset (resetb=1, async) or csr.afu_en=0 (synchronous clear):
//   - frame_number=0, pending=0, write.request=0, write_header=0.
// - Pending counter update each cycle, where grant = writer_grant & write.request:
//   - release & !grant -> pending+1
//   - !release & grant -> pending-1
//   - release & grant  -> pending unchanged
//   - Release at pending==MAX_PENDING is dropped and pending stays at max.
//     The frame reader guarantees this cannot happen.
// - write.request = (pending != 0). It is a registered output: it rises the cycle after
//   the first release pulse.
// - write_header is combinational from state. Other fields are 0.
//   - request_type = WrLine
//   - address = {frame_base_pointer, frame_number, LOG_FRAME_CHUNKS'(0)}
//   - mdata = 0
// - Handshake:
//   - Request stays asserted with a stable header until writer_grant.
//   - On grant, frame_number <= frame_number+1, wrapping modulo 2^LOG_FRAME_NUMBER in step
//     with frame_reader.
//   - A grant while request=0 is ignored.
// - Back-to-back: with pending>1, request stays high.
//   - Each consecutive grant cycle releases the next frame number, one write per cycle.
// - Releases must be written in frame order. No reordering and no merging of pending releases.
// - No other outputs. No combinational path from release_frame to frame_reader.
// - Size: a counter, a frame register, header mux and optional checks (~150 lines).
// CONFIGURATION
// - FRAME_RELEASE_DEBUG_EN defined:
//   - Simulation-only checks on top of the default behaviour below.
//   - $display of frame number and address on every granted release write.
//   - $error on a release arriving at pending==MAX_PENDING.
//   - $error on a grant while request=0.
// - Not defined: no display or assertion code.
//   - Silent drop and ignore, as described in BEHAVIOUR.
//   - Identical synthesized logic either way.
// TESTING
// - Reset and csr.afu_en:
//   - resetb=1, then 0, afu_en=1, no release -> write.request stays 0 for 20 cycles.
// - Single release:
//   - base=0x100, pulse release; grant 3 cycles later -> request 1 from cycle+1 until grant.
//   - Address = {0x100,0,0}, WrLine; frame_number then 1, request 0.
// - Burst:
//   - 3 releases with no grant -> pending=3.
//   - Grants on 3 consecutive cycles -> addresses carry frame numbers 0,1,2, then request drops.
// - Simultaneous:
//   - pending=1, release and grant in the same cycle -> pending stays 1, request stays 1.
//   - Next address uses frame 1.
// - Wrap:
//   - Release and grant 2^LOG_FRAME_NUMBER+1 frames -> last address frame field = 0.
// - afu_en cleared mid-operation:
//   - pending=2, drop afu_en one cycle -> pending=0, frame_number=0, request 0.

Source files
------------

// File: rtl/qa_frame_release_if.sv
// Shared types and the release-write handshake interface for qa_frame_release.
// Address field widths here must match frame_reader.
package qa_frame_release_pkg;

    localparam int unsigned QA_LOG_FRAME_BASE_POINTER = 26;
    localparam int unsigned QA_LOG_FRAME_NUMBER       = 4;
    localparam int unsigned QA_LOG_FRAME_CHUNKS       = 2;
    localparam int unsigned ADDR_W  = QA_LOG_FRAME_BASE_POINTER + QA_LOG_FRAME_NUMBER
                                    + QA_LOG_FRAME_CHUNKS;
    localparam int unsigned MDATA_W = 16;
    localparam int unsigned DATA_W  = 512;
    localparam int unsigned RTYPE_W = 4;

    typedef logic [RTYPE_W-1:0] req_type_t;
    localparam req_type_t WR_LINE = 4'h1;
    localparam req_type_t RD_LINE = 4'h4;

    typedef struct packed {
        logic afu_en;
    } t_CSR_AFU_STATE;

    typedef struct packed {
        req_type_t            request_type;
        logic [ADDR_W-1:0]    address;
        logic [MDATA_W-1:0]   mdata;
    } tx_header_t;

    typedef struct packed {
        logic request;
    } arb_req_t;

    typedef struct packed {
        arb_req_t             read;
        arb_req_t             write;
        tx_header_t           read_header;
        tx_header_t           write_header;
        logic [DATA_W-1:0]    data;
    } frame_arb_t;

    typedef struct packed {
        logic reader_grant;
        logic writer_grant;
    } channel_grant_arb_t;

endpackage

interface qa_frame_release_if;
    import qa_frame_release_pkg::*;

    logic               release_frame;
    channel_grant_arb_t write_grant;
    frame_arb_t         frame_reader;

    modport master (output release_frame, output write_grant, input frame_reader);
    modport slave  (input release_frame, input write_grant, output frame_reader);
endinterface

// File: rtl/qa_frame_release.sv
// Returns consumed read frames to the host: one header-line write per release pulse.
// Optional simulation checks are enabled by defining FRAME_RELEASE_DEBUG_EN.
module qa_frame_release
    import qa_frame_release_pkg::*;
#(
    parameter int unsigned MAX_PENDING            = 8,
    parameter int unsigned LOG_FRAME_BASE_POINTER = QA_LOG_FRAME_BASE_POINTER,
    parameter int unsigned LOG_FRAME_NUMBER       = QA_LOG_FRAME_NUMBER,
    parameter int unsigned LOG_FRAME_CHUNKS       = QA_LOG_FRAME_CHUNKS
) (
    input  logic                              clk,
    input  logic                              resetb,
    input  t_CSR_AFU_STATE                    csr,
    input  logic [LOG_FRAME_BASE_POINTER-1:0] frame_base_pointer,
    qa_frame_release_if.slave                 fr_if
);

    localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

    logic [PEND_W-1:0]           pending_q, pending_d;
    logic [LOG_FRAME_NUMBER-1:0] frame_q, frame_d;
    logic                        req_q, req_d;
    logic                        grant_c;
    logic                        full_c;
    tx_header_t                  hdr_c;
    logic                        unused_c;

    assign unused_c = fr_if.write_grant.reader_grant;
    assign grant_c  = fr_if.write_grant.writer_grant & req_q;
    assign full_c   = (pending_q == PEND_W'(MAX_PENDING));

    // Pending count, frame pointer and registered request for the next cycle
    always_comb begin
        pending_d = pending_q;
        frame_d   = frame_q;
        req_d     = 1'b0;
        if (!csr.afu_en) begin
            pending_d = '0;
            frame_d   = '0;
        end else begin
            if (fr_if.release_frame && !grant_c && !full_c) begin
                pending_d = pending_q + PEND_W'(1);
            end else if (!fr_if.release_frame && grant_c) begin
                pending_d = pending_q - PEND_W'(1);
            end
            if (grant_c) begin
                frame_d = frame_q + LOG_FRAME_NUMBER'(1);
            end
            req_d = (pending_d != '0);
        end
    end

    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            pending_q <= '0;
            frame_q   <= '0;
            req_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            frame_q   <= frame_d;
            req_q     <= req_d;
        end
    end

    // Header targets chunk 0 of the oldest unreleased frame; all-zero while idle
    always_comb begin
        hdr_c = '0;
        if (req_q) begin
            hdr_c.request_type = WR_LINE;
            hdr_c.address      = ADDR_W'({frame_base_pointer, frame_q,
                                          {LOG_FRAME_CHUNKS{1'b0}}});
        end
    end

    always_comb begin
        fr_if.frame_reader               = '0;
        fr_if.frame_reader.write.request = req_q;
        fr_if.frame_reader.write_header  = hdr_c;
    end

`ifdef FRAME_RELEASE_DEBUG_EN
    always @(posedge clk) begin
        if (!resetb && csr.afu_en) begin
            if (grant_c) begin
                $display("qa_frame_release: frame %0d released, address %0h",
                         frame_q, hdr_c.address);
            end
            if (fr_if.release_frame && full_c) begin
                $error("qa_frame_release: release with %0d releases already pending",
                       MAX_PENDING);
            end
            if (fr_if.write_grant.writer_grant && !req_q) begin
                $error("qa_frame_release: write grant without a request");
            end
        end
    end
`endif

endmodule

// File: tb/tb_qa_frame_release.sv
// Randomised and directed bench for qa_frame_release against a FIFO-of-frames model.
module tb_qa_frame_release;
    import qa_frame_release_pkg::*;

    localparam int unsigned MAX_PEND = 8;
    localparam int unsigned NFRAMES  = 1 << QA_LOG_FRAME_NUMBER;

    logic                                 clk;
    logic                                 resetb;
    t_CSR_AFU_STATE                       csr;
    logic [QA_LOG_FRAME_BASE_POINTER-1:0] base;

    qa_frame_release_if fr_if ();

    qa_frame_release #(.MAX_PENDING(MAX_PEND)) dut (
        .clk                (clk),
        .resetb             (resetb),
        .csr                (csr),
        .frame_base_pointer (base),
        .fr_if              (fr_if.slave)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Model: queue of frame numbers released but not yet written back
    int q[$];
    int m_next;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_addr(input logic [QA_LOG_FRAME_BASE_POINTER-1:0] b,
                                             input int f);
        return (64'(b) << (QA_LOG_FRAME_NUMBER + QA_LOG_FRAME_CHUNKS))
             | (64'(f) << QA_LOG_FRAME_CHUNKS);
    endfunction

    always @(posedge clk or posedge resetb) begin
        bit g;
        bit r;
        if (resetb || !csr.afu_en) begin
            q.delete();
            m_next = 0;
        end else begin
            g = fr_if.write_grant.writer_grant && (q.size() != 0);
            r = fr_if.release_frame;
            if (g) void'(q.pop_front());
            if (r && q.size() < MAX_PEND) begin
                q.push_back(m_next);
                m_next = (m_next + 1) % NFRAMES;
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        logic exp_req;
        exp_req = (q.size() != 0);
        chk("request", 64'(fr_if.frame_reader.write.request), 64'(exp_req));
        if (exp_req) begin
            chk("address", 64'(fr_if.frame_reader.write_header.address), exp_addr(base, q[0]));
            chk("req_type", 64'(fr_if.frame_reader.write_header.request_type), 64'(WR_LINE));
            chk("mdata", 64'(fr_if.frame_reader.write_header.mdata), 64'd0);
        end else begin
            chk("idle_header", 64'(fr_if.frame_reader.write_header), 64'd0);
        end
        chk("zero_fields", 64'(|{fr_if.frame_reader.read.request,
                                 fr_if.frame_reader.read_header,
                                 fr_if.frame_reader.data}), 64'd0);
    end

    // Inputs are held for one clock, changing 1 time unit after the rising edge
    task automatic tick(input logic rel, input logic gnt);
        fr_if.release_frame            = rel;
        fr_if.write_grant.writer_grant = gnt;
        @(posedge clk);
        #1;
        fr_if.release_frame            = 1'b0;
        fr_if.write_grant.writer_grant = 1'b0;
    endtask

    task automatic clear_en();
        csr.afu_en = 1'b0;
        tick(1'b0, 1'b0);
        csr.afu_en = 1'b1;
    endtask

    function automatic logic [63:0] dut_addr();
        return 64'(fr_if.frame_reader.write_header.address);
    endfunction

    function automatic logic [63:0] dut_req();
        return 64'(fr_if.frame_reader.write.request);
    endfunction

    initial begin
        int pr;
        int pg;
        resetb                         = 1'b1;
        csr.afu_en                     = 1'b0;
        base                           = '0;
        fr_if.release_frame            = 1'b0;
        fr_if.write_grant.reader_grant = 1'b0;
        fr_if.write_grant.writer_grant = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req", dut_req(), 64'd0);
        chk("reset_header", 64'(fr_if.frame_reader.write_header), 64'd0);

        // Out of reset, enabled, no releases
        resetb     = 1'b0;
        csr.afu_en = 1'b1;
        repeat (20) tick(1'b0, 1'b0);
        chk("idle20_req", dut_req(), 64'd0);

        // Single release, granted three cycles after the pulse
        base = 26'h100;
        tick(1'b1, 1'b0);
        chk("single_req", dut_req(), 64'd1);
        chk("single_addr", dut_addr(), 64'h4000);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        chk("single_done", dut_req(), 64'd0);
        tick(1'b1, 1'b0);
        chk("single_next_frame", dut_addr(), 64'h4004);
        tick(1'b0, 1'b1);

        // Burst of three, then three consecutive grants
        clear_en();
        repeat (3) tick(1'b1, 1'b0);
        chk("burst_addr0", dut_addr(), 64'h4000);
        tick(1'b0, 1'b1);
        chk("burst_addr1", dut_addr(), 64'h4004);
        tick(1'b0, 1'b1);
        chk("burst_addr2", dut_addr(), 64'h4008);
        tick(1'b0, 1'b1);
        chk("burst_done", dut_req(), 64'd0);

        // Release and grant in the same cycle
        clear_en();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        chk("simul_req", dut_req(), 64'd1);
        chk("simul_addr", dut_addr(), 64'h4004);
        tick(1'b0, 1'b1);
        chk("simul_done", dut_req(), 64'd0);

        // Enable dropped mid-operation
        clear_en();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        clear_en();
        chk("afu_clear_req", dut_req(), 64'd0);
        tick(1'b1, 1'b0);
        chk("afu_clear_frame", dut_addr(), 64'h4000);
        tick(1'b0, 1'b1);

        // Frame number wrap
        clear_en();
        for (int i = 0; i <= int'(NFRAMES); i++) begin
            tick(1'b1, 1'b0);
            if (i == int'(NFRAMES) - 1) chk("wrap_last", dut_addr(), 64'h403C);
            if (i == int'(NFRAMES))     chk("wrap_zero", dut_addr(), 64'h4000);
            tick(1'b0, 1'b1);
        end

        // Overflow: nine releases without grants, ninth is dropped
        clear_en();
        repeat (MAX_PEND + 1) tick(1'b1, 1'b0);
        repeat (MAX_PEND - 1) tick(1'b0, 1'b1);
        chk("ovf_last_addr", dut_addr(), 64'h401C);
        tick(1'b0, 1'b1);
        chk("ovf_drained", dut_req(), 64'd0);

        // Randomised traffic, balanced and release-heavy phases
        for (int ph = 0; ph < 4; ph++) begin
            pr = (ph % 2 == 0) ? 40 : 80;
            pg = (ph % 2 == 0) ? 50 : 25;
            base = QA_LOG_FRAME_BASE_POINTER'($urandom);
            for (int c = 0; c < 1000; c++) begin
                if ($urandom_range(0, 199) == 0) csr.afu_en = 1'b0;
                else                             csr.afu_en = 1'b1;
                if ($urandom_range(0, 499) == 0) base = QA_LOG_FRAME_BASE_POINTER'($urandom);
                tick(1'($urandom_range(0, 99) < pr), 1'($urandom_range(0, 99) < pg));
            end
        end
        csr.afu_en = 1'b1;
        repeat (40) tick(1'b0, 1'b1);
        chk("final_drain", dut_req(), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
